// File: rtl/pulse_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretcher_pkg
// Shared definitions for the pulse stretcher block:
//   - state_t   : FSM state encoding (IDLE, ON, GAP), 2 bits
//   - cnt_w()   : bits needed to hold the values 0..max_val (minimum 1)
//   - max_int() : larger of two integers, used for counter sizing
// -----------------------------------------------------------------------------
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// -----------------------------------------------------------------------------
// pulse_stretcher_if
// Event/indicator bundle between core logic and the pulse stretcher.
//   strobe_in   : event request, one cycle per event      (master -> slave)
//   led_out     : stretched, registered LED pulse          (slave -> master)
//   busy        : high while a pulse or its dark gap runs  (slave -> master)
//   pending_cnt : events queued but not yet shown          (slave -> master)
//   overflow    : one-cycle pulse when an event is lost    (slave -> master)
// Modports: master = event source / observer, slave = the stretcher.
// -----------------------------------------------------------------------------
interface pulse_stretcher_if #(
    parameter int MAX_PENDING = 3
);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    logic              strobe_in;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending_cnt;
    logic              overflow;

    modport master (
        output strobe_in,
        input  led_out,
        input  busy,
        input  pending_cnt,
        input  overflow
    );

    modport slave (
        input  strobe_in,
        output led_out,
        output busy,
        output pending_cnt,
        output overflow
    );

endinterface

// File: rtl/pulse_stretcher_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk by CLK_DIV. The counter runs 0..CLK_DIV-1 and wraps to 0; the
// tick is emitted in the cycle the counter holds CLK_DIV-1 (the wrap cycle).
// Ports:
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset
//   i_clear : synchronous clear, restarts the count at 0 on the next edge
//   o_tick  : one-cycle tick every CLK_DIV cycles
// -----------------------------------------------------------------------------
module tick_prescaler
    import pulse_stretcher_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int            PW   = cnt_w(CLK_DIV - 1);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
// Turns single-cycle strobes into human-visible LED pulses of ON_TICKS ticks,
// each followed by a forced dark gap of OFF_TICKS ticks (1 tick = CLK_DIV clk).
// Build option PULSE_STRETCHER_QUEUE_EN:
//   defined   : strobes arriving during ON/GAP are queued in a saturating
//               counter (up to MAX_PENDING) and shown back to back.
//   undefined : strobes during ON/GAP are dropped (overflow pulses for each);
//               pending_cnt is tied to 0.
// Ports:
//   i_clk   : system clock, all logic on posedge
//   i_rst_n : synchronous active-low reset
//   bus     : pulse_stretcher_if.slave (strobe_in in; led_out, busy,
//             pending_cnt, overflow out, all registered)
// -----------------------------------------------------------------------------
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int ON_TICKS    = 200,
    parameter int OFF_TICKS   = 100,
    parameter int MAX_PENDING = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    pulse_stretcher_if.slave   bus
);

    localparam int                TICK_W   = cnt_w(max_int(ON_TICKS, OFF_TICKS));
    localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_led;
    logic              r_busy;
    logic              r_ovf;
    logic              w_ovf_nxt;
    logic              w_tick;
    logic              w_clear;
    logic              w_on_done;
    logic              w_gap_done;

`ifdef PULSE_STRETCHER_QUEUE_EN
    localparam int                PEND_W   = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    logic [PEND_W-1:0] r_pend;
    logic [PEND_W-1:0] w_pend_nxt;
    logic [PEND_W-1:0] w_pend_inc;
    logic              w_pend_full;

    // Saturating increment shared by the ON and GAP arms.
    assign w_pend_full = (r_pend == PEND_MAX);
    assign w_pend_inc  = w_pend_full ? r_pend : r_pend + 1'b1;
`endif

    // Prescaler restarts on every state change so each phase is whole ticks;
    // it is also held in IDLE so the first ON tick is a full CLK_DIV long.
    assign w_clear = (w_state_nxt != r_state) || (r_state == IDLE);

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    assign w_on_done  = (r_state == ON)  && w_tick && (r_tick_cnt == ON_LAST);
    assign w_gap_done = (r_state == GAP) && w_tick && (r_tick_cnt == OFF_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_ovf_nxt   = 1'b0;
`ifdef PULSE_STRETCHER_QUEUE_EN
        w_pend_nxt  = r_pend;
`endif
        case (r_state)
            IDLE: begin
                if (bus.strobe_in) begin
                    w_state_nxt = ON;
                end
            end
            ON: begin
                if (w_on_done) begin
                    w_state_nxt = GAP;
                end
`ifdef PULSE_STRETCHER_QUEUE_EN
                if (bus.strobe_in) begin
                    w_pend_nxt = w_pend_inc;
                    w_ovf_nxt  = w_pend_full;
                end
`else
                w_ovf_nxt = bus.strobe_in;
`endif
            end
            GAP: begin
`ifdef PULSE_STRETCHER_QUEUE_EN
                if (w_gap_done) begin
                    if (r_pend != '0) begin
                        // A strobe here cancels the dequeue: count unchanged.
                        w_state_nxt = ON;
                        if (!bus.strobe_in) begin
                            w_pend_nxt = r_pend - 1'b1;
                        end
                    end else if (bus.strobe_in) begin
                        // Empty queue: the strobe starts the next pulse directly.
                        w_state_nxt = ON;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (bus.strobe_in) begin
                    w_pend_nxt = w_pend_inc;
                    w_ovf_nxt  = w_pend_full;
                end
`else
                if (w_gap_done) begin
                    w_state_nxt = bus.strobe_in ? ON : IDLE;
                end else begin
                    w_ovf_nxt = bus.strobe_in;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_led      <= 1'b0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            r_led   <= (w_state_nxt == ON);
            r_busy  <= (w_state_nxt != IDLE);
            r_ovf   <= w_ovf_nxt;
            if (w_clear) begin
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

`ifdef PULSE_STRETCHER_QUEUE_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign bus.pending_cnt = r_pend;
`else
    assign bus.pending_cnt = '0;
`endif

    assign bus.led_out  = r_led;
    assign bus.busy     = r_busy;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

    localparam int CLK_DIV     = 4;
    localparam int ON_TICKS    = 3;
    localparam int OFF_TICKS   = 2;
    localparam int MAX_PENDING = 2;
    localparam int NC          = 100;
    localparam int NV          = 7;

`ifdef PULSE_STRETCHER_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    typedef struct {
        string          name;
        logic [NC-1:0]  stb;
        logic [NC-1:0]  rstlow;
        logic [NC-1:0]  led;
        logic [NC-1:0]  busy;
        logic [NC-1:0]  ovf;
        logic [NC-1:0]  p0;
        logic [NC-1:0]  p1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_chk  = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    pulse_stretcher_if #(.MAX_PENDING(MAX_PENDING)) bus ();

    pulse_stretcher #(
        .CLK_DIV     (CLK_DIV),
        .ON_TICKS    (ON_TICKS),
        .OFF_TICKS   (OFF_TICKS),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    function automatic logic [NC-1:0] rng(input int a, input int b);
        logic [NC-1:0] m;
        m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [NC-1:0] at(input int a);
        return rng(a, a);
    endfunction

    task automatic check(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.strobe_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] pexp;
        do_reset();
        for (int c = 0; c < NC; c++) begin
            bus.strobe_in = v.stb[c];
            rst_n         = ~v.rstlow[c];
            pexp          = {v.p1[c], v.p0[c]};
            check({v.name, ".led_out"},     c, 32'(bus.led_out),     32'(v.led[c]));
            check({v.name, ".busy"},        c, 32'(bus.busy),        32'(v.busy[c]));
            check({v.name, ".overflow"},    c, 32'(bus.overflow),    32'(v.ovf[c]));
            check({v.name, ".pending_cnt"}, c, 32'(bus.pending_cnt), 32'(pexp));
            @(posedge clk);
            #1;
        end
        bus.strobe_in = 1'b0;
        rst_n = 1'b1;
    endtask

    // Measures one isolated pulse: rise latency, ON width, GAP width, IDLE after.
    task automatic measure();
        int w, hi, lo;
        do_reset();
        bus.strobe_in = 1'b1;
        @(posedge clk);
        #1;
        bus.strobe_in = 1'b0;
        w = 0;
        while (!bus.led_out && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        hi = 0;
        while (bus.led_out && hi < 100) begin
            hi++;
            @(posedge clk);
            #1;
        end
        lo = 0;
        while (bus.busy && !bus.led_out && lo < 100) begin
            lo++;
            @(posedge clk);
            #1;
        end
        check("rise_latency", 0, 32'(w), 32'd0);
        check("on_width", 0, 32'(hi), 32'(ON_TICKS * CLK_DIV));
        check("gap_width", 0, 32'(lo), 32'(OFF_TICKS * CLK_DIV));
        check("idle_after_gap.busy", 0, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.strobe_in = 1'b0;

        vecs[0].name = "single"; vecs[0].stb = at(10); vecs[0].rstlow = '0;
        vecs[0].led = rng(11, 22); vecs[0].busy = rng(11, 30);
        vecs[0].ovf = '0; vecs[0].p0 = '0; vecs[0].p1 = '0;

        vecs[1].name = "queue3"; vecs[1].stb = at(10) | at(14) | at(16); vecs[1].rstlow = '0;
        vecs[1].led  = QEN ? (rng(11, 22) | rng(31, 42) | rng(51, 62)) : rng(11, 22);
        vecs[1].busy = QEN ? rng(11, 70) : rng(11, 30);
        vecs[1].ovf  = QEN ? '0 : (at(15) | at(17));
        vecs[1].p0   = QEN ? (rng(15, 16) | rng(31, 50)) : '0;
        vecs[1].p1   = QEN ? rng(17, 30) : '0;

        vecs[2].name = "saturate"; vecs[2].stb = at(10) | at(12) | at(13) | at(14); vecs[2].rstlow = '0;
        vecs[2].led  = QEN ? (rng(11, 22) | rng(31, 42) | rng(51, 62)) : rng(11, 22);
        vecs[2].busy = QEN ? rng(11, 70) : rng(11, 30);
        vecs[2].ovf  = QEN ? at(15) : (at(13) | at(14) | at(15));
        vecs[2].p0   = QEN ? (at(13) | rng(31, 50)) : '0;
        vecs[2].p1   = QEN ? rng(14, 30) : '0;

        vecs[3].name = "last_gap"; vecs[3].stb = at(10) | at(30); vecs[3].rstlow = '0;
        vecs[3].led = rng(11, 22) | rng(31, 42); vecs[3].busy = rng(11, 50);
        vecs[3].ovf = '0; vecs[3].p0 = '0; vecs[3].p1 = '0;

        vecs[4].name = "mid_reset"; vecs[4].stb = at(10) | at(12) | at(20); vecs[4].rstlow = at(15);
        vecs[4].led  = rng(11, 15) | rng(21, 32);
        vecs[4].busy = rng(11, 15) | rng(21, 40);
        vecs[4].ovf  = QEN ? '0 : at(13);
        vecs[4].p0   = QEN ? rng(13, 15) : '0;
        vecs[4].p1   = '0;

        vecs[5].name = "held_level"; vecs[5].stb = rng(10, 12); vecs[5].rstlow = '0;
        vecs[5].led  = QEN ? (rng(11, 22) | rng(31, 42) | rng(51, 62)) : rng(11, 22);
        vecs[5].busy = QEN ? rng(11, 70) : rng(11, 30);
        vecs[5].ovf  = QEN ? '0 : (at(12) | at(13));
        vecs[5].p0   = QEN ? (at(12) | rng(31, 50)) : '0;
        vecs[5].p1   = QEN ? rng(13, 30) : '0;

        vecs[6].name = "full_cancel"; vecs[6].stb = at(10) | at(12) | at(13) | at(30); vecs[6].rstlow = '0;
        vecs[6].led  = QEN ? (rng(11, 22) | rng(31, 42) | rng(51, 62) | rng(71, 82))
                           : (rng(11, 22) | rng(31, 42));
        vecs[6].busy = QEN ? rng(11, 90) : rng(11, 50);
        vecs[6].ovf  = QEN ? '0 : (at(13) | at(14));
        vecs[6].p0   = QEN ? (at(13) | rng(51, 70)) : '0;
        vecs[6].p1   = QEN ? rng(14, 50) : '0;

        for (int k = 0; k < NV; k++) run_vec(vecs[k]);

        measure();

        // Strobe on the final ON cycle is counted (queue) or dropped (no queue).
        do_reset();
        for (int c = 0; c < 32; c++) begin
            bus.strobe_in = (c == 10) || (c == 22);
            if (c == 23) begin
                check("final_on.pending_cnt", c, 32'(bus.pending_cnt), QEN ? 32'd1 : 32'd0);
                check("final_on.overflow",    c, 32'(bus.overflow),    QEN ? 32'd0 : 32'd1);
            end
            if (c == 31) begin
                check("final_on.led_out", c, 32'(bus.led_out), QEN ? 32'd1 : 32'd0);
            end
            @(posedge clk);
            #1;
        end
        bus.strobe_in = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
